// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_fsm_cell.sv
// Full subtractor cell: d = a - b - bin, one bit.
// Purely combinational, reused every SHIFT cycle.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow out of one bit position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor_fsm.sv
// Bit-serial WIDTH-bit subtractor D = A - B - B_IN, LSB first.
// Optional OVF output when SERIAL_SUB_OVF_EN is defined.
import serial_sub_pkg::*;

module serial_subtractor_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
  output logic             OVF,
`endif
  output logic             B_OUT
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             b_next;
  logic [WIDTH-1:0] res_next;

  full_subtractor_cell u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (b_next)
  );

  // New difference bit enters at the MSB of the result
  assign res_next = {d_bit, res[WIDTH-1:1]};

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      D     <= '0;
      B_OUT <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      OVF   <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (START) begin
            sa    <= A;
            sb    <= B;
            br    <= B_IN;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          br  <= b_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            D     <= res_next;
            B_OUT <= b_next;
`ifdef SERIAL_SUB_OVF_EN
            OVF   <= br ^ b_next;
`endif
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Self-checking bench for serial_subtractor_fsm.
// Define SERIAL_SUB_OVF_EN to cover the OVF output.
module tb_serial_subtractor_fsm;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         B_IN = 1'b0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] D;
  logic         B_OUT;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  int n_chk = 0;
  int n_fail = 0;

  serial_subtractor_fsm #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .B_IN  (B_IN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .D     (D),
`ifdef SERIAL_SUB_OVF_EN
    .OVF   (OVF),
`endif
    .B_OUT (B_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unsigned reference: {borrow, diff} from wide arithmetic
  function automatic logic [W:0] ref_sub(
    logic [W-1:0] a, logic [W-1:0] b, logic bin);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    return r;
  endfunction

  // Signed reference: result outside the W-bit signed range
  function automatic logic ref_ovf(
    logic [W-1:0] a, logic [W-1:0] b, logic bin);
    int s;
    s = int'($signed(a)) - int'($signed(b)) - int'(bin);
    return (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
  endfunction

  // Present operands and hold START across one edge
  task automatic launch(
    string tag, logic [W-1:0] a, logic [W-1:0] b, logic bin);
    A = a; B = b; B_IN = bin; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk({tag, ".busy_hi"}, BUSY, 1);
    chk({tag, ".done_lo0"}, DONE, 0);
  endtask

  // Step W edges after the accept edge; DONE must appear on the last
  task automatic wait_done(
    string tag, logic [W-1:0] ed, logic eb, logic eo,
    int pulse_k, logic [W-1:0] pa, logic [W-1:0] pb);
    for (int k = 1; k <= W; k++) begin
      @(posedge CLK); #1;
      if (k < W) begin
        chk({tag, ".done_early"}, DONE, 0);
        chk({tag, ".busy_mid"}, BUSY, 1);
      end else begin
        chk({tag, ".done"}, DONE, 1);
        chk({tag, ".busy_lo"}, BUSY, 0);
        chk({tag, ".d"}, D, ed);
        chk({tag, ".b_out"}, B_OUT, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, ".ovf"}, OVF, eo);
`endif
      end
      if (k == pulse_k) begin
        START = 1'b1; A = pa; B = pb; B_IN = ~B_IN;
      end else if (k == pulse_k + 1) begin
        START = 1'b0;
      end
    end
    if (eo === 1'bx) $display("unused");
  endtask

  // One more edge: DONE drops, result held, back to idle
  task automatic finish_op(string tag, logic [W-1:0] ed);
    @(posedge CLK); #1;
    chk({tag, ".done_pulse"}, DONE, 0);
    chk({tag, ".d_held"}, D, ed);
    chk({tag, ".idle"}, BUSY, 0);
  endtask

  task automatic run_op(
    string tag, logic [W-1:0] a, logic [W-1:0] b, logic bin,
    logic [W-1:0] ed, logic eb, logic eo);
    launch(tag, a, b, bin);
    wait_done(tag, ed, eb, eo, -10, '0, '0);
    finish_op(tag, ed);
  endtask

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ra, rb;
    logic         rc;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst.busy", BUSY, 0);
    chk("rst.done", DONE, 0);
    chk("rst.d", D, 0);
    chk("rst.b_out", B_OUT, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst.ovf", OVF, 0);
`endif
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("idle.busy", BUSY, 0);

    run_op("t35", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    run_op("t00", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("t10", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("tff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    run_op("ov1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ov0", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
`endif

    // Mid-SHIFT START ignored, then START held into FIN
    launch("ign", 8'h35, 8'h12, 1'b0);
    wait_done("ign", 8'h23, 1'b0, 1'b0, 3, 8'hAA, 8'h55);
    launch("b2b", 8'h00, 8'h01, 1'b0);
    wait_done("b2b", 8'hFF, 1'b1, 1'b0, -10, '0, '0);
    finish_op("b2b", 8'hFF);

    // Reset mid-operation discards the partial result
    launch("rmid", 8'h5A, 8'h21, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rmid.busy", BUSY, 0);
    chk("rmid.done", DONE, 0);
    chk("rmid.d", D, 0);
    chk("rmid.b_out", B_OUT, 0);
    @(posedge CLK); #1;
    chk("rmid.idle", BUSY, 0);
    run_op("post", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);

    // Random operands, sometimes chained back-to-back
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      r  = ref_sub(ra, rb, rc);
      launch("rnd", ra, rb, rc);
      wait_done("rnd", r[W-1:0], r[W], ref_ovf(ra, rb, rc),
                -10, '0, '0);
      if ($urandom_range(0, 1) == 0) finish_op("rnd", r[W-1:0]);
    end
    finish_op("last", r[W-1:0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
